seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the board's common-anode seven-segment display bank. It owns one shared 4-bit hex-to-segment decoder and time-shares it across `DIGITS` digit positions: it presents one nibble at a time on `nib` and enables exactly one digit via `dig_n`. It inserts a blanking gap between digits to suppress ghosting, and accepts new display values through a valid/ready handshake. New values are applied only at frame boundaries, so a count never tears. It sits between the game's score/counter logic and the top-level display pins.

---
 rtl/seg_scan_pkg.sv | 15 +
 rtl/seg_scan_timer.sv | 33 +++
 rtl/seg_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Build option: SEG_SCAN_LZB_EN enables leading-zero blanking.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_GAP
  } state_t;

  localparam int NIB_W = 4;

  localparam logic [7:0] DIG_OFF = 8'hFF;

endpackage

// File: rtl/seg_scan_timer.sv
// Slot counter for the scan controller.
// gap_start marks the last lit cycle; slot_end marks the last slot cycle.
module seg_scan_timer #(
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic gap_start,
  output logic slot_end
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] GAP_AT = CW'(DIV - BLANK_CYC - 1);
  localparam logic [CW-1:0] END_AT = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign gap_start = (cnt == GAP_AT);
  assign slot_end  = (cnt == END_AT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode digit scanner with tear-free updates.
// Build option: SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter int DIV       = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*DIGITS-1:0]     val_data,
  input  logic                    val_valid,
  output logic                    val_ready,
  output logic [NIB_W-1:0]        nib,
  output logic [DIGITS-1:0]       dig_n,
  output logic                    blank,
  output logic                    frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] OFF = DIG_OFF[DIGITS-1:0];

  state_t              state;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_nxt;
  logic [4*DIGITS-1:0] shadow;
  logic [4*DIGITS-1:0] pending;
  logic                pend_v;
  logic                wrap_q;
  logic                gap_start;
  logic                slot_end;
  logic                clr;
  logic                run;
  logic                xfer;
  logic                wrap;
  logic                apply;
  logic                show;

  seg_scan_timer #(
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .gap_start (gap_start),
    .slot_end  (slot_end)
  );

  assign clr     = !en || (state == S_IDLE);
  assign run     = en && (state != S_IDLE);
  assign xfer    = val_valid && val_ready;
  assign wrap    = run && slot_end && (idx == LAST);
  assign apply   = pend_v && ((state == S_IDLE) || wrap);
  assign idx_nxt = (idx == LAST) ? '0 : idx + 1'b1;

`ifdef SEG_SCAN_LZB_EN
  assign show = (idx == '0) || ((shadow >> (NIB_W * idx)) != '0);
`else
  assign show = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      shadow     <= '0;
      pending    <= '0;
      pend_v     <= 1'b0;
      wrap_q     <= 1'b0;
      val_ready  <= 1'b1;
      nib        <= '0;
      dig_n      <= OFF;
      blank      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      wrap_q     <= wrap;
      frame_done <= wrap_q;
      // ready stays low for the cycle in which the slot is released
      val_ready  <= !pend_v && !xfer;

      if (apply) begin
        shadow <= pending;
        pend_v <= 1'b0;
      end
      if (xfer) begin
        pending <= val_data;
        pend_v  <= 1'b1;
      end

      if (!en || state != S_ON) begin
        dig_n <= OFF;
        blank <= 1'b1;
      end else begin
        nib   <= shadow[NIB_W*idx +: NIB_W];
        dig_n <= show ? ~(DIGITS'(1) << idx) : OFF;
        blank <= !show;
      end

      if (!en) begin
        state <= S_IDLE;
        idx   <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            state <= S_ON;
            idx   <= '0;
          end
          S_ON: begin
            if (slot_end) begin
              idx <= idx_nxt;
            end else if (gap_start) begin
              state <= S_GAP;
            end
          end
          S_GAP: begin
            if (slot_end) begin
              state <= S_ON;
              idx   <= idx_nxt;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position model plus pinned literals.
// Build option: SEG_SCAN_LZB_EN selects the leading-zero blanking expectations.
module tb_seg_scan_ctrl;

  localparam int DIGITS    = 4;
  localparam int DIV       = 8;
  localparam int BLANK_CYC = 2;
  localparam int FRAME     = DIGITS * DIV;
`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] val_data = '0;
  logic        val_valid = 1'b0;
  logic        val_ready;
  logic [3:0]  nib;
  logic [3:0]  dig_n;
  logic        blank;
  logic        frame_done;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIGITS    (DIGITS),
    .DIV       (DIV),
    .BLANK_CYC (BLANK_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .val_data   (val_data),
    .val_valid  (val_valid),
    .val_ready  (val_ready),
    .nib        (nib),
    .dig_n      (dig_n),
    .blank      (blank),
    .frame_done (frame_done)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               name, got, exp, $time);
    end
  endtask

  // Offer queue: each value is held on val_data until accepted.
  logic [15:0] offers[$];
  bit rdy_seen = 1'b0;

  always @(negedge clk) begin
    if (val_valid && rdy_seen) val_valid = 1'b0;
    if (!val_valid && offers.size() > 0) begin
      val_data  = offers.pop_front();
      val_valid = 1'b1;
    end
    rdy_seen = val_ready;
  end

  // Model: position within the frame, display value, one pending slot.
  bit          act;
  int          p;
  int          d;
  int          ph;
  bit          vis;
  bit          xf;
  bit          bnd;
  bit          ap;
  logic [15:0] m_sh;
  logic [15:0] m_pend;
  bit          m_pv;
  bit          m_fdq;
  bit          model_ok = 1'b0;
  logic [3:0]  e_dig;
  logic [3:0]  e_nib;
  logic        e_blank;
  logic        e_fd;
  logic        e_vr;

  always @(posedge clk) begin
    if (rst) begin
      act = 0; p = 0; m_sh = '0; m_pend = '0;
      m_pv = 0; m_fdq = 0;
      e_dig = 4'hF; e_nib = 4'h0; e_blank = 1'b1;
      e_fd = 1'b0; e_vr = 1'b1;
      model_ok = 1'b1;
    end else begin
      xf = val_valid && e_vr;
      d  = p / DIV;
      ph = p % DIV;
      if (en && act && ph < DIV - BLANK_CYC) begin
        vis = !LZB || d == 0 ||
              (32'(m_sh) / (32'd1 << (4 * d))) != 0;
        e_nib   = m_sh[4*d +: 4];
        e_dig   = vis ? ~(4'd1 << d) : 4'hF;
        e_blank = !vis;
      end else begin
        e_dig   = 4'hF;
        e_blank = 1'b1;
      end
      bnd   = en && act && p == FRAME - 1;
      e_fd  = m_fdq;
      m_fdq = bnd;
      ap    = m_pv && (!act || bnd);
      e_vr  = !m_pv && !xf;
      if (ap) begin m_sh = m_pend; m_pv = 0; end
      if (xf) begin m_pend = val_data; m_pv = 1; end
      if (!en) begin
        act = 0; p = 0;
      end else if (!act) begin
        act = 1; p = 0;
      end else begin
        p = (p + 1) % FRAME;
      end
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("cmp_dig_n", 32'(dig_n), 32'(e_dig));
      check("cmp_nib", 32'(nib), 32'(e_nib));
      check("cmp_blank", 32'(blank), 32'(e_blank));
      check("cmp_frame_done", 32'(frame_done), 32'(e_fd));
      check("cmp_val_ready", 32'(val_ready), 32'(e_vr));
    end
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dig_n", 32'(dig_n), 32'hF);
    check("rst_blank", 32'(blank), 32'h1);
    check("rst_val_ready", 32'(val_ready), 32'h1);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    rst = 1'b0;

    offers.push_back(16'h1234);
    repeat (4) @(negedge clk);
    en = 1'b1;
    for (int k = 0; k <= 115; k++) begin
      @(negedge clk);
      case (k)
        1: begin
          check("l1_dig", 32'(dig_n), 32'hE);
          check("l1_nib", 32'(nib), 32'h4);
        end
        6: check("l6_dig", 32'(dig_n), 32'hE);
        7: check("l7_gap", 32'(dig_n), 32'hF);
        9: begin
          check("l9_dig", 32'(dig_n), 32'hD);
          check("l9_nib", 32'(nib), 32'h3);
        end
        17: check("l17_nib", 32'(nib), 32'h2);
        25: begin
          check("l25_dig", 32'(dig_n), 32'h7);
          check("l25_nib", 32'(nib), 32'h1);
        end
        32: check("l32_fd", 32'(frame_done), 32'h0);
        33: begin
          check("l33_fd", 32'(frame_done), 32'h1);
          check("l33_nib", 32'(nib), 32'h4);
        end
        42: offers.push_back(16'hABCD);
        46: check("t46_rdy", 32'(val_ready), 32'h0);
        48: offers.push_back(16'h5678);
        49: check("t49_nib", 32'(nib), 32'h2);
        57: check("t57_nib", 32'(nib), 32'h1);
        64: check("b64_rdy", 32'(val_ready), 32'h0);
        65: begin
          check("t65_fd", 32'(frame_done), 32'h1);
          check("t65_nib", 32'(nib), 32'hD);
          check("t65_rdy", 32'(val_ready), 32'h1);
        end
        66: check("b66_rdy", 32'(val_ready), 32'h0);
        73: check("t73_nib", 32'(nib), 32'hC);
        89: check("t89_nib", 32'(nib), 32'hA);
        97: check("b97_nib", 32'(nib), 32'h8);
        114: begin
          check("a114_dig", 32'(dig_n), 32'hB);
          check("a114_nib", 32'(nib), 32'h6);
          en = 1'b0;
        end
        115: begin
          check("a115_dig", 32'(dig_n), 32'hF);
          check("a115_blank", 32'(blank), 32'h1);
        end
        default: ;
      endcase
    end

    repeat (3) @(negedge clk);
    en = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("r1_dig", 32'(dig_n), 32'hE);
        check("r1_nib", 32'(nib), 32'h8);
      end
      if (k == 7) check("r7_gap", 32'(dig_n), 32'hF);
      if (k == 9) check("r9_nib", 32'(nib), 32'h7);
    end

    en = 1'b0;
    offers.push_back(16'h0007);
    repeat (5) @(negedge clk);
    en = 1'b1;
    for (int k = 0; k <= 26; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("z1_dig", 32'(dig_n), 32'hE);
        check("z1_nib", 32'(nib), 32'h7);
      end
      if (k == 9) begin
        check("z9_dig", 32'(dig_n), LZB ? 32'hF : 32'hD);
        check("z9_blank", 32'(blank), LZB ? 32'h1 : 32'h0);
      end
      if (k == 25) begin
        check("z25_dig", 32'(dig_n), LZB ? 32'hF : 32'h7);
        check("z25_nib", 32'(nib), 32'h0);
      end
    end

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = 1'b0;
      if ($urandom_range(0, 99) < 2) en = !en;
      else if ($urandom_range(0, 99) < 3) en = 1'b1;
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      if (offers.size() == 0 && $urandom_range(0, 29) == 0)
        offers.push_back(16'($urandom));
    end
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
